// File: rtl/rec_play_pkg.sv
// Shared types and width helpers for the record/playback controller.
// The loop-playback option is selected with the REC_PLAY_LOOP_EN macro.
package rec_play_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned CNT_W      = ADDR_W_DEF + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REC  = 2'd1,
      S_PLAY = 2'd2
   } state_e;

   // Counter is one bit wider than the address so a full memory is representable
   function automatic int unsigned cnt_width(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/sample_addr_counter.sv
// Sample counter: synchronous clear, gated increment, terminal-count compare.
module sample_addr_counter
   import rec_play_pkg::*;
#(
   parameter int unsigned CNT_W = rec_play_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] count,
   output logic             tc_c
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc_c = (count == term);

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer driving sample-memory address and strobes.
// Define REC_PLAY_LOOP_EN to make playback loop until a button stops it.
module rec_play_ctrl
   import rec_play_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned MAX_SAMPLES = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rec_pulse,
   input  logic              play_pulse,
   input  logic              sample_tick,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic              rec_active,
   output logic              play_active,
   output logic [ADDR_W:0]   rec_len
);

   localparam int unsigned CTR_W = cnt_width(ADDR_W);

   state_e             state;
   state_e             state_nxt;
   logic               cnt_clr;
   logic               cnt_inc;
   logic [CTR_W-1:0]   count;
   logic [CTR_W-1:0]   term_c;
   logic               tc_c;
   logic [ADDR_W-1:0]  addr_nxt;
   logic               we_nxt;
   logic               re_nxt;
   logic [CTR_W-1:0]   len_nxt;

   // Terminal value: capacity while recording, recording length while playing
`ifdef REC_PLAY_LOOP_EN
   assign term_c = (state == S_PLAY) ? (rec_len - CTR_W'(1)) : CTR_W'(MAX_SAMPLES);
`else
   assign term_c = (state == S_PLAY) ? rec_len : CTR_W'(MAX_SAMPLES);
`endif

   sample_addr_counter #(
      .CNT_W (CTR_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .term  (term_c),
      .count (count),
      .tc_c  (tc_c)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         rec_active  <= 1'b0;
         play_active <= 1'b0;
         rec_len     <= '0;
      end else begin
         state       <= state_nxt;
         mem_addr    <= addr_nxt;
         mem_we      <= we_nxt;
         mem_re      <= re_nxt;
         rec_active  <= (state_nxt == S_REC);
         play_active <= (state_nxt == S_PLAY);
         rec_len     <= len_nxt;
      end
   end

   // Next state; stop pulses beat sample ticks, terminal count beats ticks
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      addr_nxt  = mem_addr;
      we_nxt    = 1'b0;
      re_nxt    = 1'b0;
      len_nxt   = rec_len;
      case (state)
         S_IDLE: begin
            if (rec_pulse) begin
               state_nxt = S_REC;
               cnt_clr   = 1'b1;
               addr_nxt  = '0;
            end else if (play_pulse && (rec_len != '0)) begin
               state_nxt = S_PLAY;
               cnt_clr   = 1'b1;
               addr_nxt  = '0;
            end
         end
         S_REC: begin
            if (rec_pulse || tc_c) begin
               state_nxt = S_IDLE;
               len_nxt   = count;
            end else if (sample_tick) begin
               we_nxt   = 1'b1;
               addr_nxt = count[ADDR_W-1:0];
               cnt_inc  = 1'b1;
            end
         end
         S_PLAY: begin
            if (rec_pulse || play_pulse) begin
               state_nxt = S_IDLE;
`ifdef REC_PLAY_LOOP_EN
            end else if (sample_tick) begin
               re_nxt   = 1'b1;
               addr_nxt = count[ADDR_W-1:0];
               cnt_clr  = tc_c;
               cnt_inc  = !tc_c;
            end
`else
            end else if (tc_c) begin
               state_nxt = S_IDLE;
            end else if (sample_tick) begin
               re_nxt   = 1'b1;
               addr_nxt = count[ADDR_W-1:0];
               cnt_inc  = 1'b1;
            end
`endif
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Scoreboard bench for rec_play_ctrl: a behavioural model queues expected
// memory strobes; a negedge monitor pops and compares them.
module tb_rec_play_ctrl;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned MAXS   = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rec_pulse = 1'b0;
   logic              play_pulse = 1'b0;
   logic              sample_tick = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   logic              rec_active;
   logic              play_active;
   logic [ADDR_W:0]   rec_len;

   rec_play_ctrl #(.ADDR_W(ADDR_W), .MAX_SAMPLES(MAXS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rec_pulse   (rec_pulse),
      .play_pulse  (play_pulse),
      .sample_tick (sample_tick),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .rec_active  (rec_active),
      .play_active (play_active),
      .rec_len     (rec_len)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_REC, M_PLAY} mode_t;
   typedef struct {
      bit wr;
      int addr;
   } strobe_t;

   mode_t   mode = M_IDLE;
   int      n = 0;
   int      len = 0;
   strobe_t exp_q[$];
   strobe_t got;
   int      n_checks = 0;
   int      n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Recorder behaviour, one clock cycle at a time
   task automatic model_step(input bit r, input bit p, input bit t);
      strobe_t e;
      case (mode)
         M_IDLE: begin
            if (r) begin
               mode = M_REC; n = 0;
            end else if (p && len != 0) begin
               mode = M_PLAY; n = 0;
            end
         end
         M_REC: begin
            if (r || n == int'(MAXS)) begin
               len = n; mode = M_IDLE;
            end else if (t) begin
               e.wr = 1'b1; e.addr = n; exp_q.push_back(e); n++;
            end
         end
         M_PLAY: begin
            if (r || p) begin
               mode = M_IDLE;
`ifdef REC_PLAY_LOOP_EN
            end else if (t) begin
               e.wr = 1'b0; e.addr = n; exp_q.push_back(e); n = (n + 1) % len;
            end
`else
            end else if (n == len) begin
               mode = M_IDLE;
            end else if (t) begin
               e.wr = 1'b0; e.addr = n; exp_q.push_back(e); n++;
            end
`endif
         end
         default: mode = M_IDLE;
      endcase
   endtask

   task automatic step(input bit r, input bit p, input bit t);
      rec_pulse = r; play_pulse = p; sample_tick = t;
      @(posedge clk);
      #1;
      model_step(r, p, t);
      rec_pulse = 1'b0; play_pulse = 1'b0; sample_tick = 1'b0;
   endtask

   task automatic ticks(input int count);
      for (int i = 0; i < count; i++) begin
         step(1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b0);
      end
   endtask

   // Monitor: pop an expected strobe whenever the DUT issues one
   always @(negedge clk) begin
      chk("we_re_exclusive", int'(mem_we & mem_re), 0);
      if (mem_we || mem_re) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got we=%0d re=%0d addr=%0d, expected none (t=%0t)",
                     mem_we, mem_re, mem_addr, $time);
         end else begin
            got = exp_q.pop_front();
            chk("strobe_is_write", int'(mem_we), int'(got.wr));
            chk("strobe_addr", int'(mem_addr), got.addr);
         end
      end
      chk("rec_active", int'(rec_active), int'(mode == M_REC));
      chk("play_active", int'(play_active), int'(mode == M_PLAY));
      chk("rec_len", int'(rec_len), len);
   end

   initial begin
      int r, p, t;
      #3;
      chk("reset_addr", int'(mem_addr), 0);
      chk("reset_we", int'(mem_we), 0);
      chk("reset_re", int'(mem_re), 0);
      chk("reset_rec_active", int'(rec_active), 0);
      chk("reset_play_active", int'(play_active), 0);
      chk("reset_rec_len", int'(rec_len), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // PLAY with nothing recorded is ignored
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("play_empty_ignored", int'(play_active), 0);

      // Record five samples, tick coinciding with the start pulse is dropped
      step(1'b1, 1'b0, 1'b1);
      ticks(5);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("rec5_len", int'(rec_len), 5);
      chk("rec5_idle", int'(rec_active), 0);

      // Play back with one surplus tick
      step(1'b0, 1'b1, 1'b0);
      ticks(6);
      chk("play5_idle", int'(play_active), 0);
      chk("play5_len_kept", int'(rec_len), 5);

      // REC wins contention; PLAY during REC ignored; memory fills at 8
      step(1'b1, 1'b1, 1'b0);
      chk("contention_rec", int'(rec_active), 1);
      step(1'b0, 1'b1, 1'b0);
      chk("play_in_rec_ignored", int'(rec_active), 1);
      ticks(10);
      step(1'b0, 1'b0, 1'b0);
      chk("full_len", int'(rec_len), int'(MAXS));
      chk("full_idle", int'(rec_active), 0);

      // Back-to-back ticks then stop by PLAY mid-playback
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("play_stop", int'(play_active), 0);

      // Reset while recording after three writes
      step(1'b1, 1'b0, 1'b0);
      ticks(3);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      mode = M_IDLE; n = 0; len = 0;
      exp_q.delete();
      #1;
      chk("midrst_addr", int'(mem_addr), 0);
      chk("midrst_rec_active", int'(rec_active), 0);
      chk("midrst_rec_len", int'(rec_len), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef REC_PLAY_LOOP_EN
      step(1'b1, 1'b0, 1'b0);
      ticks(3);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      ticks(7);
      chk("loop_still_playing", int'(play_active), 1);
      step(1'b0, 1'b1, 1'b0);
      chk("loop_stop", int'(play_active), 0);
`endif

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 99) < 3) ? 1 : 0;
         p = ($urandom_range(0, 99) < 4) ? 1 : 0;
         t = ($urandom_range(0, 99) < 45) ? 1 : 0;
         step(r[0], p[0], t[0]);
      end
      step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
